lab3_sequence_generator: RTL
============================

Name: lab3_sequence_generator

Overview:
Serial bit-stream transmitter that drives the single-bit `x` input of the lab's sequence recognizers. It loads a parallel pattern and shifts it out MSB-first, one bit per clock. It can repeat the frame a programmable number of times with idle gaps between frames. It is the stimulus-side counterpart used on the Lab3 board and bench to feed recognizer FSMs with controlled sequences.

Parameters:
WIDTH, 8, maximum pattern length in bits (2..16)
GAP_CYCLES, 2, idle cycles inserted between repeated frames (0..15)
IDLE_LEVEL, 1'b0, value driven on x whenever no frame bit is being sent

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin transmission; sampled only in IDLE
pattern  input  WIDTH  bits to send; pattern[len-1] is sent first
len  input  5  number of pattern bits per frame; values above WIDTH are clamped to WIDTH
repeats  input  4  number of additional frames after the first (0 = send once)
x  output  1  serial data bit, registered
x_valid  output  1  high in every cycle x carries a frame bit, registered
busy  output  1  high from the cycle after start is accepted until DONE is exited
done  output  1  one-cycle pulse at the end of the whole transmission

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, even mid-frame:
  - state=IDLE
  - x=IDLE_LEVEL, x_valid=0, busy=0, done=0
  - shift register, bit counter, repeat counter and gap counter all cleared
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered (Moore).
- IDLE:
  - x=IDLE_LEVEL, x_valid=0.
  - On `start`=1 with effective len>=1: capture pattern, clamped len, and repeats into internal registers; go to SHIFT.
  - On `start`=1 with len=0: go to DONE. No bits are sent.
- Latency: if start is sampled at edge k, the first frame bit appears on x with x_valid=1 in the cycle after edge k, and busy=1 in that same cycle.
- SHIFT:
  - Each cycle drives the next bit, MSB-first starting at bit len-1, with x_valid=1. Bit counter decrements per cycle.
  - After the last bit (bit 0): if repeat counter >0, decrement it and go to GAP (or straight back to SHIFT if GAP_CYCLES=0); otherwise go to DONE.
- GAP:
  - x=IDLE_LEVEL, x_valid=0, for exactly GAP_CYCLES cycles.
  - Then reload the shift register from the captured pattern (not the live `pattern` input) and go to SHIFT.
- DONE:
  - done=1 and busy=1 for exactly one cycle; x=IDLE_LEVEL, x_valid=0.
  - Next state is IDLE, where busy=0.
- `start` is ignored in SHIFT, GAP and DONE; it is never queued.
- Changes on pattern, len or repeats while busy have no effect on the transmission in progress.
- Total busy cycles = F*L + (F-1)*GAP_CYCLES + 1, where F=repeats+1 and L=clamped len.

Optional Feature:
Macro SEQGEN_PARITY_EN.
- When defined: each frame is followed by one extra bit equal to the even parity (XOR) of the L frame bits, sent with x_valid=1 before GAP or DONE. The busy-cycle formula uses L+1 in place of L.
- When undefined: no parity bit, no parity logic, and timing is exactly as in Behaviour.

Test Plan:
- Reset mid-frame: reset=1 while in SHIFT -> in the same cycle x=0, x_valid=0, busy=0; a later start sends the frame from the first bit.
- Single frame: pattern=8'b0000_0010, len=3, repeats=0, start pulse -> x_valid high for 3 cycles with x=0,1,0; done pulses once in the following cycle; busy high for 4 cycles.
- Repeat with gap: pattern=8'b1001_0110, len=8, repeats=2, GAP_CYCLES=2 -> three copies of 1,0,0,1,0,1,1,0, each separated by 2 cycles of x_valid=0; busy high for 29 cycles.
- Edge lengths: len=0 -> done pulse one cycle after start, x_valid never high. len=20 with WIDTH=8 -> exactly 8 bits sent.
- Start and input changes while busy: start re-pulsed and pattern changed during SHIFT -> output stream unchanged, no second transmission afterwards.
- Parity (SEQGEN_PARITY_EN defined): pattern=3'b011, len=3 -> x = 0,1,1,0 with x_valid high for 4 cycles.

Source files
------------

// File: rtl/lab3_sequence_generator.sv
// ============================================================================
// Module      : lab3_sequence_generator
// Description : Serial MSB-first pattern transmitter with programmable frame
//               repeats and idle gaps. Define SEQGEN_PARITY_EN to append an
//               even-parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab3_sequence_generator #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [4:0]       len,
    input  logic [3:0]       repeats,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] c_WIDTH5 = 5'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_GAP    = 3'd2,
        S_DONE   = 3'd3,
        S_PARITY = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [4:0]         len_q, len_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [3:0]         rep_q, rep_d;
    logic [3:0]         gap_q, gap_d;

    logic [4:0]         w_len_eff;
    logic [WIDTH-1:0]   w_aligned;
    logic               w_frame_end;
    logic               w_reload;

    // Pattern is left-aligned so the first bit to send is always the MSB;
    // bits above len are shifted out and never transmitted.
    assign w_len_eff = (len > c_WIDTH5) ? c_WIDTH5 : len;
    assign w_aligned = pattern << (c_WIDTH5 - w_len_eff);

    always_comb begin
        state_d     = state_q;
        x_d         = IDLE_LEVEL;
        x_valid_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sh_d        = sh_q;
        pat_d       = pat_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        w_frame_end = 1'b0;
        w_reload    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (w_len_eff != 5'd0) begin
                        pat_d     = w_aligned;
                        len_d     = w_len_eff;
                        rep_d     = repeats;
                        state_d   = S_SHIFT;
                        x_d       = w_aligned[WIDTH-1];
                        x_valid_d = 1'b1;
                        sh_d      = w_aligned << 1;
                        cnt_d     = w_len_eff - 5'd1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q != 5'd0) begin
                    x_d       = sh_q[WIDTH-1];
                    x_valid_d = 1'b1;
                    sh_d      = sh_q << 1;
                    cnt_d     = cnt_q - 5'd1;
                end else begin
`ifdef SEQGEN_PARITY_EN
                    state_d   = S_PARITY;
                    x_d       = ^pat_q;
                    x_valid_d = 1'b1;
`else
                    w_frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQGEN_PARITY_EN
            S_PARITY: w_frame_end = 1'b1;
`endif
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    w_reload = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_frame_end) begin
            if (rep_q != 4'd0) begin
                rep_d = rep_q - 4'd1;
                if (GAP_CYCLES == 0) begin
                    w_reload = 1'b1;
                end else begin
                    state_d = S_GAP;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        // Repeated frames come from the captured copy, never the live input.
        if (w_reload) begin
            state_d   = S_SHIFT;
            x_d       = pat_q[WIDTH-1];
            x_valid_d = 1'b1;
            sh_d      = pat_q << 1;
            cnt_d     = len_q - 5'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= IDLE_LEVEL;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sh_q      <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sh_q      <= sh_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire
